// File: rtl/fifo_mem.sv
// fifo_mem -- DEPTH x DATA_BW register array used as FIFO storage.
//   clk   : clock, all updates on rising edge
//   rst   : synchronous active-low reset, clears every entry to 0
//   we    : write enable, writes wdata at waddr
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : asynchronous read of entry raddr
module fifo_mem #(
  parameter int ADDR_BW = 1,
  parameter int DATA_BW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [DATA_BW-1:0] wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [DATA_BW-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_BW;

  logic [DATA_BW-1:0] mem_q [DEPTH];

  // Flop array rather than block RAM: every entry must clear on reset and the
  // read side is combinational so the head word falls through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_thr.sv
// fifo_thr -- first-word fall-through FIFO with programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow flags.
//   clk          : clock, all state updates on rising edge
//   rst          : synchronous active-low reset (highest priority)
//   wr_din       : push request, data on din
//   rd_dout      : pop request
//   flush        : discard all contents (overrides push/pop)
//   err_clr      : clear sticky error flags (a same-cycle error wins)
//   afull_thr    : almost_full when num_item >= afull_thr
//   aempty_thr   : almost_empty when num_item <= aempty_thr
//   dout         : head-of-queue data
//   full, empty  : occupancy flags
//   num_item     : occupancy 0..DEPTH
//   overflow     : sticky, set by a rejected push
//   underflow    : sticky, set by a rejected pop
module fifo_thr #(
  parameter int ADDR_BW = 1,
  parameter int DATA_BW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_din,
  input  logic               rd_dout,
  input  logic               flush,
  input  logic               err_clr,
  input  logic [DATA_BW-1:0] din,
  input  logic [ADDR_BW:0]   afull_thr,
  input  logic [ADDR_BW:0]   aempty_thr,
  output logic [DATA_BW-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [ADDR_BW:0]   num_item,
  output logic               overflow,
  output logic               underflow
);
  localparam int               DEPTH     = 2 ** ADDR_BW;
  localparam logic [ADDR_BW:0] DEPTH_CNT = (ADDR_BW + 1)'(DEPTH);

  logic [ADDR_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BW:0]   num_item_q, num_item_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               push_ok, pop_ok;

  fifo_mem #(
    .ADDR_BW(ADDR_BW),
    .DATA_BW(DATA_BW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (push_ok),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(dout)
  );

  assign full         = (num_item_q == DEPTH_CNT);
  assign empty        = (num_item_q == '0);
  assign almost_full  = (num_item_q >= afull_thr);
  assign almost_empty = (num_item_q <= aempty_thr);
  assign num_item     = num_item_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    // A push into a full FIFO is fine when a pop frees the head slot the
    // same cycle; a pop from an empty FIFO is never accepted, even with a push.
    push_ok = !flush && wr_din && (!full || rd_dout);
    pop_ok  = !flush && rd_dout && !empty;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    num_item_d = num_item_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      num_item_d = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_BW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_BW'(1);
      if (push_ok && !pop_ok) num_item_d = num_item_q + (ADDR_BW + 1)'(1);
      if (pop_ok && !push_ok) num_item_d = num_item_q - (ADDR_BW + 1)'(1);
    end

    // Set term is ORed after the clear so a same-cycle error keeps the flag.
    overflow_d  = (overflow_q && !err_clr) ||
                  (!flush && wr_din && full && !rd_dout);
    underflow_d = (underflow_q && !err_clr) ||
                  (!flush && rd_dout && empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      num_item_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      num_item_q  <= num_item_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule
